// File: rtl/fp_shift_pkg.sv
// Shared definitions for the FP mantissa shift pipeline.
// Mode encodings and shift direction.
package fp_shift_pkg;

  localparam logic [1:0] SHM_LEFT  = 2'b00;
  localparam logic [1:0] SHM_RIGHT = 2'b01;
  localparam logic [1:0] SHM_NORM  = 2'b10;
  localparam logic [1:0] SHM_PASS  = 2'b11;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } shdir_e;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
// All-zero input reports cnt 0 with zero set.
module fp_lzc #(
  parameter  int WIDTH = 24,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [SHW-1:0]   cnt_o,
  output logic             zero_o
);

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    cnt_o  = '0;
    zero_o = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) begin
        cnt_o  = SHW'(WIDTH - 1 - i);
        zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_norm_shift_pipe.sv
// Pipelined mantissa shifter: left, right+sticky,
// normalise or pass-through, with optional level registers.
module fp_norm_shift_pipe
  import fp_shift_pkg::*;
#(
  parameter  int          WIDTH    = 24,
  parameter  int          TAG_W    = 8,
  parameter  logic [31:0] REG_MASK = 32'b00100,
  localparam int          SHW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_amt,
  output logic             out_sticky,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    shdir_e           dir;
    logic             sticky;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic           adv;
  logic [SHW-1:0] lz_cnt;
  logic           lz_zero;
  stage_t         s0_d;
  stage_t         s0_q;
  stage_t         stg [SHW+1];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  fp_lzc #(.WIDTH(WIDTH)) u_lzc (
    .data_i (in_data),
    .cnt_o  (lz_cnt),
    .zero_o (lz_zero)
  );

  always_comb begin
    s0_d        = '0;
    s0_d.valid  = in_valid;
    s0_d.data   = in_data;
    s0_d.zero   = lz_zero;
    s0_d.tag    = in_tag;
    s0_d.dir    = DIR_LEFT;
    unique case (in_mode)
      SHM_LEFT:  s0_d.amt = in_amt;
      SHM_RIGHT: begin
        s0_d.amt = in_amt;
        s0_d.dir = DIR_RIGHT;
      end
      SHM_NORM:  s0_d.amt = lz_cnt;
      default:   s0_d.amt = '0;
    endcase
    if (lz_zero) begin
      s0_d.amt  = '0;
      s0_d.data = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= '0;
    end else if (adv) begin
      s0_q <= s0_d;
    end
  end

  assign stg[0] = s0_q;

  for (genvar i = 0; i < SHW; i++) begin : g_lvl
    localparam int SH = 1 << (SHW - 1 - i);
    localparam logic [WIDTH-1:0] LOMASK =
      {WIDTH{1'b1}} >> (WIDTH - SH);
    stage_t lvl_d;

    always_comb begin
      lvl_d = stg[i];
      if (stg[i].amt[SHW-1-i]) begin
        if (stg[i].dir == DIR_RIGHT) begin
          lvl_d.data   = stg[i].data >> SH;
          lvl_d.sticky = stg[i].sticky
                       | (|(stg[i].data & LOMASK));
        end else begin
          lvl_d.data = stg[i].data << SH;
        end
      end
    end

    if (REG_MASK[i]) begin : g_reg
      stage_t lvl_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lvl_q <= '0;
        end else if (adv) begin
          lvl_q <= lvl_d;
        end
      end
      assign stg[i+1] = lvl_q;
    end else begin : g_comb
      assign stg[i+1] = lvl_d;
    end
  end

  assign out_valid  = stg[SHW].valid;
  assign out_data   = stg[SHW].data;
  assign out_amt    = stg[SHW].amt;
  assign out_sticky = stg[SHW].sticky;
  assign out_zero   = stg[SHW].zero;
  assign out_tag    = stg[SHW].tag;

endmodule
